uart: RTL and testbench

Memory-mapped transmit-only UART peripheral on the picorv32 native memory bus, decoded at address region 0x2xxxxxxx. It is the consumer of the system bus mux's `uart_valid` select, and its `uart_ready`/`uart_rdata` feed the core-side ready/rdata mux. Writes go into a small TX FIFO. A baud-rate FSM drains the FIFO onto a single 8N1 serial line.

---
 rtl/uart_if.sv | 28 ++
 rtl/uart.sv | 202 ++++++++++++++++++++
 tb/tb_uart.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_if.sv
// picorv32 native memory bus slice seen by the UART peripheral.
// The bus master drives the request; the UART answers with ready/rdata.
interface uart_if;
    logic        uart_valid;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic        uart_ready;
    logic [31:0] uart_rdata;

    modport master (
        output uart_valid,
        output uart_addr,
        output uart_wdata,
        output uart_wstrb,
        input  uart_ready,
        input  uart_rdata
    );

    modport slave (
        input  uart_valid,
        input  uart_addr,
        input  uart_wdata,
        input  uart_wstrb,
        output uart_ready,
        output uart_rdata
    );
endinterface

// File: rtl/uart.sv
// Transmit-only 8N1 UART on the picorv32 native bus.
// Bus writes fill a TX FIFO that a bit-timer FSM drains onto uart_tx.
module uart #(
    parameter int DEFAULT_DIV = 104,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic clk,
    input  logic reset,
    uart_if.slave bus,
    output logic uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [15:0] div_q;
    logic [15:0] eff_div;
    logic [15:0] frame_div;
    logic [15:0] timer;
    logic        tick;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        shift_en;
    logic        tx_q;
    logic        tx_d;

    logic        ready_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_val;
    logic [1:0]  sel;
    logic        is_tx_wr;
    logic        stall;
    logic        accept;
    logic        busy;
    logic [31:0] status;
    logic        unused;

    assign sel      = bus.uart_addr[3:2];
    assign is_tx_wr = (sel == 2'd0) && bus.uart_wstrb[0];
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign stall    = is_tx_wr && full;
    // The ready cycle itself never accepts: the core still holds valid then.
    assign accept   = bus.uart_valid && !ready_q && !stall;
    assign push     = accept && is_tx_wr;

    assign busy   = (state_q != IDLE) || !empty;
    assign status = {16'b0, 8'(count), 5'b0, empty, full, busy};

    assign bus.uart_ready = ready_q;
    assign bus.uart_rdata = rdata_q;
    assign uart_tx        = tx_q;

    assign unused = ^{bus.uart_addr[31:4], bus.uart_addr[1:0],
                      bus.uart_wdata[31:16], bus.uart_wstrb[3:2]};

    always_comb begin
        rd_val = '0;
        unique case (sel)
            2'd1:    rd_val = status;
            2'd2:    rd_val = {16'b0, div_q};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            div_q   <= 16'(DEFAULT_DIV);
        end else begin
            ready_q <= accept;
            rdata_q <= accept ? rd_val : '0;
            if (accept && sel == 2'd2) begin
                if (bus.uart_wstrb[0]) div_q[7:0]  <= bus.uart_wdata[7:0];
                if (bus.uart_wstrb[1]) div_q[15:8] <= bus.uart_wdata[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.uart_wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Divisors below 2 would collapse the bit period, so they clamp to 2.
    assign eff_div = (div_q < 16'd2) ? 16'd2 : div_q;
    assign tick    = (timer == 16'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        tx_d     = tx_q;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d     = shreg[1];
                        shift_en = 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (!empty) begin
                        state_d = START;
                        pop     = 1'b1;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // The divisor is sampled only at frame start so a frame never changes rate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q      <= 1'b1;
            timer     <= '0;
            frame_div <= 16'd2;
            shreg     <= '0;
            bit_cnt   <= '0;
        end else begin
            tx_q <= tx_d;
            if (pop) begin
                shreg     <= mem[rptr];
                frame_div <= eff_div;
                timer     <= eff_div - 16'd1;
                bit_cnt   <= '0;
            end else if (state_q != IDLE) begin
                if (tick) begin
                    timer <= frame_div - 16'd1;
                    if (shift_en) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end else begin
                    timer <= timer - 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for the bus-mapped TX UART.
// Serial line is traced per cycle and compared with frames built from bytes.
module tb_uart;

    localparam int TR = 40000;
    localparam logic [31:0] A_TX  = 32'h2000_0000;
    localparam logic [31:0] A_ST  = 32'h2000_0004;
    localparam logic [31:0] A_DIV = 32'h2000_0008;
    localparam logic [31:0] A_RSV = 32'h2000_000C;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx;

    uart_if bif ();

    uart #(
        .DEFAULT_DIV(104),
        .FIFO_DEPTH (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bif.slave),
        .uart_tx(tx)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic trace [TR];
    int   checks = 0;
    int   passes = 0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) if (cyc < TR) trace[cyc] = tx;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic xfer(input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, output logic [31:0] rd,
                        output int scyc, output int rcyc);
        int n;
        @(posedge clk);
        #1;
        bif.uart_valid = 1'b1;
        bif.uart_addr  = addr;
        bif.uart_wdata = wd;
        bif.uart_wstrb = strb;
        scyc = cyc;
        rcyc = -1;
        rd   = '0;
        n    = 0;
        while (rcyc < 0 && n < 5000) begin
            @(negedge clk);
            if (bif.uart_ready) begin
                rcyc = cyc;
                rd   = bif.uart_rdata;
            end
            n++;
        end
        bif.uart_valid = 1'b0;
        bif.uart_wstrb = 4'b0;
        if (rcyc < 0) begin
            checks++;
            $error("FAIL bus_timeout observed=none expected=ready addr=%h", addr);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, output int rcyc);
        logic [31:0] rd;
        int s;
        xfer(addr, wd, strb, rd, s, rcyc);
    endtask

    task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp,
                          input string tag);
        logic [31:0] rd;
        int s, r;
        xfer(addr, 32'h0, 4'b0, rd, s, r);
        check(tag, rd, exp);
    endtask

    function automatic int eff(input logic [15:0] d);
        return (d < 16'd2) ? 2 : int'(d);
    endfunction

    // Expected line: start bit 0, data LSB first, stop bit 1, e cycles each.
    task automatic check_frames(input int start, input int e, input string tag);
        for (int f = 0; f < exp_q.size(); f++) begin
            for (int b = 0; b < 10; b++) begin
                logic [7:0] byt;
                logic expb;
                int ones;
                byt  = exp_q[f];
                expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byt[b-1];
                ones = 0;
                for (int k = 0; k < e; k++)
                    ones += int'(trace[start + f*10*e + b*e + k]);
                check($sformatf("%s_f%0d_b%0d", tag, f, b), 32'(ones),
                      expb ? 32'(e) : 32'd0);
            end
        end
        check({tag, "_idle"}, 32'(trace[start + exp_q.size()*10*e]), 32'd1);
    endtask

    task automatic run_frames(input logic [15:0] d, input string tag);
        int r, first_r, e;
        e = eff(d);
        wr(A_DIV, {16'h0, d}, 4'b0011, r);
        first_r = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            wr(A_TX, {24'h0, exp_q[i]}, 4'b0001, r);
            if (i == 0) first_r = r;
        end
        repeat (10*e*exp_q.size() + 4) @(negedge clk);
        check({tag, "_pre"}, 32'(trace[first_r]), 32'd1);
        check({tag, "_fall"}, 32'(trace[first_r + 1]), 32'd0);
        check_frames(first_r + 1, e, tag);
        rd_chk(A_ST, 32'h4, {tag, "_status"});
    endtask

    initial begin
        logic [31:0] rd;
        int s, r, r1, prev, pulses, consec;
        logic [15:0] old;

        bif.uart_valid = 1'b0;
        bif.uart_addr  = '0;
        bif.uart_wdata = '0;
        bif.uart_wstrb = '0;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(bif.uart_ready), 32'd0);
        check("rst_rdata", bif.uart_rdata, 32'd0);
        reset = 1'b0;

        xfer(A_ST, 32'h0, 4'b0, rd, s, r);
        check("status_reset", rd, 32'h4);
        check("read_latency", 32'(r - s), 32'd1);
        rd_chk(A_DIV, 32'd104, "div_reset");
        rd_chk(A_RSV, 32'h0, "rsv_read");
        rd_chk(A_TX, 32'h0, "txdata_read");

        @(posedge clk);
        #1;
        bif.uart_valid = 1'b1;
        bif.uart_addr  = A_RSV;
        prev = 0;
        pulses = 0;
        consec = 0;
        repeat (8) begin
            @(negedge clk);
            if (bif.uart_ready) begin
                pulses++;
                if (prev != 0) consec++;
            end
            prev = int'(bif.uart_ready);
        end
        bif.uart_valid = 1'b0;
        check("hold_consec", 32'(consec), 32'd0);
        check("hold_pulsed", 32'(pulses > 0), 32'd1);

        exp_q = '{8'h55};
        run_frames(16'd4, "f55");
        exp_q = '{8'hA3, 8'h0F};
        run_frames(16'd4, "b2b");
        exp_q = '{8'($urandom)};
        run_frames(16'd0, "div0");

        for (int it = 0; it < 5; it++) begin
            int n;
            logic [15:0] d;
            d = 16'($urandom_range(0, 6));
            n = $urandom_range(1, 4);
            exp_q.delete();
            for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
            run_frames(d, $sformatf("rnd%0d", it));
        end

        wr(A_DIV, 32'd100, 4'b0011, r);
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'($urandom));
        r1 = 0;
        for (int i = 0; i < 9; i++) begin
            wr(A_TX, {24'h0, exp_q[i]}, 4'b0001, r);
            if (i == 0) r1 = r;
        end
        rd_chk(A_ST, 32'h0000_0803, "full_status");
        wr(A_TX, {24'h0, exp_q[9]}, 4'b0001, r);
        check("stall_ready", 32'(r), 32'(r1 + 1 + 1000 + 1));
        repeat (10000) @(negedge clk);
        check_frames(r1 + 1, 100, "stall");
        rd_chk(A_ST, 32'h4, "stall_done");

        old = 16'($urandom);
        wr(A_DIV, {16'h0, old}, 4'b0011, r);
        wr(A_DIV, 32'h0000_0300, 4'b0010, r);
        rd_chk(A_DIV, {16'h0, (old & 16'h00FF) | 16'h0300}, "div_hi_byte");
        wr(A_DIV, 32'hFFFF_FFFF, 4'b0100, r);
        rd_chk(A_DIV, {16'h0, (old & 16'h00FF) | 16'h0300}, "div_no_strb");
        wr(A_RSV, 32'hFFFF_FFFF, 4'b1111, r);
        rd_chk(A_RSV, 32'h0, "rsv_write");
        wr(A_TX, 32'h0000_AA00, 4'b0010, r);
        rd_chk(A_ST, 32'h4, "tx_no_strb");

        wr(A_DIV, 32'd4, 4'b0011, r);
        wr(A_TX, 32'h0, 4'b0001, r);
        while (cyc < r + 8) @(negedge clk);
        check("mid_frame_low", 32'(tx), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_chk(A_ST, 32'h4, "post_rst_status");
        rd_chk(A_DIV, 32'd104, "post_rst_div");
        repeat (50) @(negedge clk);
        check("post_rst_idle", 32'(tx), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
